// File: rtl/clb_param.sv
// Parametrised configurable logic block: NUM_LUT slices of LUT_K-input LUTs with
// optional registered outputs, loaded at runtime through a serial config chain.
module clb_param #(
    parameter int  LUT_K      = 4,
    parameter int  NUM_LUT    = 2,
    localparam int TBL        = 2 ** LUT_K,
    localparam int SLICE_BITS = TBL + 4,
    localparam int CFG_BITS   = NUM_LUT * SLICE_BITS,
    localparam int CNT_W      = $clog2(CFG_BITS + 1)
) (
    input  logic                       K,
    input  logic                       RST,
    input  logic                       CFG_EN,
    input  logic                       CFG_IN,
    output logic                       CFG_OUT,
    output logic                       CFG_DONE,
    input  logic                       CE,
    input  logic                       SR,
    input  logic [NUM_LUT*LUT_K-1:0]   IN,
    output logic [NUM_LUT-1:0]         OUT,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [CFG_BITS-1:0]   cfg, cfg_nx;
    logic                  cnt_last, load_init, run_active, slice_upd;
    logic                  done_r;

    // Config chain: every K edge with CFG_EN=1 shifts CFG_IN in at bit 0; the chain
    // has no backpressure, and CFG_EN=0 simply freezes it wherever it is.
    assign cfg_nx = {cfg[CFG_BITS-2:0], CFG_IN};

    always_ff @(posedge K or posedge RST) begin
        if (RST) state <= UNCFG;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            UNCFG:   if (CFG_EN) state_nx = LOAD;
            LOAD:    if (CFG_EN && (cnt == CNT_LAST)) state_nx = RUN;
            RUN:     if (CFG_EN) state_nx = LOAD;
            default: state_nx = UNCFG;
        endcase
    end

    always_comb begin
        cnt_last   = (state == LOAD) && (cnt == CNT_LAST);
        load_init  = CFG_EN && cnt_last;
        run_active = (state == RUN);
        slice_upd  = run_active && !CFG_EN;
    end

    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            cfg    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_nx == RUN);
            if (CFG_EN) begin
                cfg <= cfg_nx;
                if (cnt_last)            cnt <= '0;
                else if (state == LOAD)  cnt <= cnt + CNT_ONE;
                else                     cnt <= CNT_ONE;
            end
        end
    end

    assign CFG_OUT   = cfg[CFG_BITS-1];
    assign CFG_DONE  = done_r;
    assign state_dbg = state;

    for (genvar s = 0; s < NUM_LUT; s++) begin : g_slice
        localparam int B = s * SLICE_BITS;

        logic [TBL-1:0]   tbl;
        logic             reg_sel, ce_en, fb, lut, q;
        logic [LUT_K-1:0] in_s, addr;

        assign tbl     = cfg[B +: TBL];
        assign reg_sel = cfg[B+TBL];
        assign ce_en   = cfg[B+TBL+2];
        assign fb      = cfg[B+TBL+3];
        assign in_s    = IN[s*LUT_K +: LUT_K];

        // Feedback replaces the LUT address MSB with the slice's own register.
        assign addr = {fb ? q : in_s[LUT_K-1], in_s[LUT_K-2:0]};
        assign lut  = tbl[addr];

        always_ff @(posedge K or posedge RST) begin
            if (RST) begin
                q <= 1'b0;
            end else if (load_init) begin
                q <= cfg_nx[B+TBL+1];
            end else if (slice_upd) begin
                if (SR)                q <= cfg[B+TBL+1];
                else if (!ce_en || CE) q <= lut;
            end
        end

        assign OUT[s] = run_active & (reg_sel ? q : lut);
    end

endmodule

// File: tb/tb_clb_param.sv
// Bench for clb_param: two chained instances driven per cycle, checked against a
// bit-level behavioural model through an expected-observation queue.
module tb_clb_param;

    localparam int LUT_K      = 4;
    localparam int NUM_LUT    = 2;
    localparam int SLICE_BITS = 20;
    localparam int CFG_BITS   = 40;
    localparam int W          = 8;

    logic                      K = 1'b0;
    logic                      RST = 1'b1;
    logic                      cfg_en = 1'b0, cfg_in = 1'b0, ce = 1'b0, sr = 1'b0;
    logic [NUM_LUT*LUT_K-1:0]  in_v = '0;
    logic                      cfg_out0, cfg_out1, done0, done1;
    logic [NUM_LUT-1:0]        out0, out1;
    logic [1:0]                st0, st1;

    always #5 K = ~K;

    clb_param #(.LUT_K(LUT_K), .NUM_LUT(NUM_LUT)) u_up (
        .K(K), .RST(RST), .CFG_EN(cfg_en), .CFG_IN(cfg_in), .CFG_OUT(cfg_out0),
        .CFG_DONE(done0), .CE(ce), .SR(sr), .IN(in_v), .OUT(out0), .state_dbg(st0)
    );

    clb_param #(.LUT_K(LUT_K), .NUM_LUT(NUM_LUT)) u_dn (
        .K(K), .RST(RST), .CFG_EN(cfg_en), .CFG_IN(cfg_out0), .CFG_OUT(cfg_out1),
        .CFG_DONE(done1), .CE(ce), .SR(sr), .IN(in_v), .OUT(out1), .state_dbg(st1)
    );

    // ---------------- reference model ----------------
    logic [CFG_BITS-1:0] m_cfg [2];
    int                  m_shifted [2];
    bit                  m_run [2];
    bit                  m_q [2][NUM_LUT];

    function automatic logic [SLICE_BITS-1:0] make_slice(input logic [15:0] tbl, input bit reg_s,
                                                         input bit init, input bit ce_en, input bit fb);
        return {fb, ce_en, init, reg_s, tbl};
    endfunction

    function automatic bit m_lut(input int d, input int s);
        logic [SLICE_BITS-1:0] sl;
        int addr;
        sl   = m_cfg[d][s*SLICE_BITS +: SLICE_BITS];
        addr = int'(in_v[s*LUT_K +: LUT_K]);
        if (sl[19]) addr = (addr % 8) + (m_q[d][s] ? 8 : 0);
        return sl[addr];
    endfunction

    function automatic logic [3:0] m_obs(input int d);
        logic [3:0] o;
        logic [SLICE_BITS-1:0] sl;
        o = '0;
        o[3] = m_run[d];
        o[2] = m_cfg[d][CFG_BITS-1];
        for (int s = 0; s < NUM_LUT; s++) begin
            sl = m_cfg[d][s*SLICE_BITS +: SLICE_BITS];
            if (m_run[d]) o[s] = sl[16] ? m_q[d][s] : m_lut(d, s);
        end
        return o;
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_cfg[d] = '0;
            m_shifted[d] = 0;
            m_run[d] = 0;
            for (int s = 0; s < NUM_LUT; s++) m_q[d][s] = 0;
        end
    endfunction

    function automatic void m_edge();
        bit cin [2];
        bit nq [NUM_LUT];
        logic [SLICE_BITS-1:0] sl;
        cin[0] = cfg_in;
        cin[1] = m_cfg[0][CFG_BITS-1];
        for (int d = 0; d < 2; d++) begin
            if (cfg_en) begin
                m_cfg[d] = {m_cfg[d][CFG_BITS-2:0], cin[d]};
                if (m_run[d]) begin
                    m_run[d] = 0;
                    m_shifted[d] = 1;
                end else begin
                    m_shifted[d]++;
                    if (m_shifted[d] == CFG_BITS) begin
                        m_run[d] = 1;
                        m_shifted[d] = 0;
                        for (int s = 0; s < NUM_LUT; s++)
                            m_q[d][s] = m_cfg[d][s*SLICE_BITS + 17];
                    end
                end
            end else if (m_run[d]) begin
                for (int s = 0; s < NUM_LUT; s++) begin
                    sl = m_cfg[d][s*SLICE_BITS +: SLICE_BITS];
                    nq[s] = m_q[d][s];
                    if (sr)                  nq[s] = sl[17];
                    else if (!sl[18] || ce)  nq[s] = m_lut(d, s);
                end
                for (int s = 0; s < NUM_LUT; s++) m_q[d][s] = nq[s];
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q [$];
    bit           chk = 0;
    int           total = 0;
    int           bad = 0;

    always @(negedge K) begin
        logic [W-1:0] e, got;
        if (chk) begin
            got = {done1, cfg_out1, out1, done0, cfg_out0, out0};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL obs: no expected entry, got=%b", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL obs t=%0t: got {done1,cout1,out1,done0,cout0,out0}=%b exp=%b",
                             $time, got, e);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic cyc(input bit en, input bit din, input bit ce_i, input bit sr_i,
                       input logic [NUM_LUT*LUT_K-1:0] in_i);
        cfg_en = en; cfg_in = din; ce = ce_i; sr = sr_i; in_v = in_i;
        exp_q.push_back({m_obs(1), m_obs(0)});
        chk = 1;
        @(negedge K);
        @(posedge K);
        m_edge();
        #1;
    endtask

    task automatic do_rst();
        RST = 1'b1;
        m_reset();
        exp_q.push_back({m_obs(1), m_obs(0)});
        chk = 1;
        @(negedge K);
        @(posedge K);
        #1;
        RST = 1'b0;
    endtask

    task automatic shift_bits(input logic [CFG_BITS-1:0] c, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) cyc(1, c[i], 1'($urandom), 1'($urandom), 8'($urandom));
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 1'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom));
    endtask

    function automatic logic [CFG_BITS-1:0] rand_cfg();
        return {make_slice(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)),
                make_slice(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom))};
    endfunction

    logic [CFG_BITS-1:0] cfg_a, cfg_fb, cfg_b;

    initial begin
        m_reset();
        @(posedge K);
        #1;
        do_rst();

        // Reset mid-load: outputs clear before the next edge, then a full reload is needed.
        cfg_a = {make_slice(16'h8000, 1, 1, 1, 0), make_slice(16'h6996, 0, 0, 0, 0)};
        shift_bits(cfg_a, 39, 20);
        do_rst();
        shift_bits(cfg_a, 39, 0);

        // Comb parity slice and registered AND slice with clock enable.
        cyc(0, 0, 0, 0, 8'hF1);
        cyc(0, 0, 1, 0, 8'hF1);
        cyc(0, 0, 1, 0, 8'hE1);
        cyc(0, 0, 0, 0, 8'hE1);
        cyc(0, 0, 1, 0, 8'hF0);

        // Clock enable low holds; SR wins over CE=0.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 8'hF0);
        cyc(0, 0, 0, 1, 8'hF0);
        cyc(0, 0, 0, 0, 8'hF0);
        cyc(0, 0, 0, 0, 8'h0F);
        run_rand(20);

        // Feedback toggle: registered slice0 inverts its own Q each edge.
        cfg_fb = {make_slice(16'($urandom), 0, 0, 0, 0), make_slice(16'h00FF, 1, 0, 0, 1)};
        shift_bits(cfg_fb, 39, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1'($urandom), 0, 8'($urandom));

        // Load paused for 8 cycles, then resumed; reconfiguration drops out of RUN.
        cfg_b = rand_cfg();
        shift_bits(cfg_b, 39, 30);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1'($urandom), 1'($urandom), 8'($urandom));
        shift_bits(cfg_b, 29, 0);
        run_rand(10);
        cyc(1, 1'($urandom), 1, 0, 8'($urandom));
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 8'($urandom));

        // Chained load: the first 40 bits land in the downstream block.
        for (int r = 0; r < 4; r++) begin
            cfg_b = rand_cfg();
            cfg_a = rand_cfg();
            shift_bits(cfg_b, 39, 0);
            shift_bits(cfg_a, 39, 0);
            run_rand(30);
        end

        @(negedge K);
        chk = 0;
        if (exp_q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
